// File: rtl/ecu_board_ctrl.sv
// rtl/ecu_board_ctrl.sv - key debounce, core reset/boot sequencer and LED mux for the board
module ecu_board_ctrl #(
  parameter int          NUM_KEYS        = 4,
  parameter int          NUM_LEDS        = 10,
  parameter int          DEBOUNCE_CYCLES = 500000,
  parameter int          RST_HOLD_CYCLES = 1024,
  parameter logic [31:0] BOOT_ADDR_0     = 32'h0000_8000,
  parameter logic [31:0] BOOT_ADDR_1     = 32'h0000_0000
) (
  input  logic                CLK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  input  logic [NUM_LEDS-1:0] gpio_i,
  output logic [NUM_LEDS-1:0] LEDR,
  output logic                sys_reset_n,
  output logic                jtag_reset,
  output logic                fetch_enable,
  output logic [31:0]         boot_addr,
  output logic [NUM_KEYS-1:0] key_pressed,
  output logic [NUM_KEYS-1:0] key_event
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {ST_RESET, ST_HOLD, ST_RUN} state_t;

  state_t                      state_q, state_d;
  logic [NUM_KEYS-1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_KEYS-1:0]         key_pressed_q, key_pressed_d;
  logic [NUM_KEYS-1:0]         key_event_q, key_event_d;
  logic [NUM_KEYS-1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [HW-1:0]               hold_cnt_q, hold_cnt_d;
  logic                        boot_sel_q, boot_sel_d;
  logic                        sys_reset_n_q, sys_reset_n_d;
  logic                        fetch_enable_q, fetch_enable_d;
  logic                        jtag_reset_q, jtag_reset_d;
  logic [31:0]                 boot_addr_q, boot_addr_d;
  logic [NUM_LEDS-1:0]         ledr_q, ledr_d;
  logic [NUM_KEYS-1:0]         key_sync;

  // Synchronizer holds raw board levels (1 = released); invert afterwards.
  assign key_sync = ~sync2_q;

  always_comb begin
    sync1_d       = KEY;
    sync2_d       = sync1_q;
    key_pressed_d = key_pressed_q;
    deb_cnt_d     = deb_cnt_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_sync[i] != key_pressed_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          key_pressed_d[i] = ~key_pressed_q[i];
          deb_cnt_d[i]     = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
        end
      end else begin
        deb_cnt_d[i] = '0;
      end
    end
    key_event_d = key_pressed_d & ~key_pressed_q;
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    boot_sel_d = boot_sel_q;
    case (state_q)
      ST_RESET: begin
        if (!key_pressed_q[0]) begin
          state_d    = ST_HOLD;
          hold_cnt_d = '0;
          boot_sel_d = key_pressed_q[1];
        end
      end
      ST_HOLD: begin
        if (key_pressed_q[0]) begin
          state_d = ST_RESET;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (key_pressed_q[0]) begin
          state_d = ST_RESET;
        end
      end
      default: state_d = ST_RESET;
    endcase

    // Reset press drops both core enables on the very next edge.
    sys_reset_n_d  = (state_q == ST_RUN) && !key_pressed_q[0];
    fetch_enable_d = sys_reset_n_d && sys_reset_n_q;
    jtag_reset_d   = key_pressed_q[0];
    boot_addr_d    = boot_sel_d ? BOOT_ADDR_1 : BOOT_ADDR_0;

    ledr_d = '0;
    if (state_q == ST_RUN) begin
      ledr_d = gpio_i;
    end else begin
      ledr_d[NUM_LEDS-1] = 1'b1;
      ledr_d[0]          = boot_sel_q;
    end
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= ST_RESET;
      sync1_q        <= '1;
      sync2_q        <= '1;
      key_pressed_q  <= '0;
      key_event_q    <= '0;
      deb_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      boot_sel_q     <= 1'b0;
      sys_reset_n_q  <= 1'b0;
      fetch_enable_q <= 1'b0;
      jtag_reset_q   <= 1'b0;
      boot_addr_q    <= BOOT_ADDR_0;
      ledr_q         <= '0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      key_pressed_q  <= key_pressed_d;
      key_event_q    <= key_event_d;
      deb_cnt_q      <= deb_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      boot_sel_q     <= boot_sel_d;
      sys_reset_n_q  <= sys_reset_n_d;
      fetch_enable_q <= fetch_enable_d;
      jtag_reset_q   <= jtag_reset_d;
      boot_addr_q    <= boot_addr_d;
      ledr_q         <= ledr_d;
    end
  end

  assign LEDR         = ledr_q;
  assign sys_reset_n  = sys_reset_n_q;
  assign jtag_reset   = jtag_reset_q;
  assign fetch_enable = fetch_enable_q;
  assign boot_addr    = boot_addr_q;
  assign key_pressed  = key_pressed_q;
  assign key_event    = key_event_q;

endmodule

// File: tb/tb_ecu_board_ctrl.sv
// tb/tb_ecu_board_ctrl.sv - self-checking bench for ecu_board_ctrl
module tb_ecu_board_ctrl;

  localparam int          NK   = 4;
  localparam int          NL   = 10;
  localparam int          DEB  = 4;
  localparam int          HOLD = 8;
  localparam logic [31:0] B0   = 32'h0000_8000;
  localparam logic [31:0] B1   = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key;
  logic [NL-1:0] gpio;
  logic [NL-1:0] ledr;
  logic          sys_reset_n, jtag_reset, fetch_enable;
  logic [31:0]   boot_addr;
  logic [NK-1:0] key_pressed, key_event;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: debounce as "disagreed for DEB straight cycles",
  // sequencer as a count of consecutive edges with the reset key released.
  logic [NK-1:0] dly0, dly1, m_kp, m_evt;
  int            streak [NK];
  int            quiet;
  logic          m_bsel, m_srst, m_fe, m_jtag;
  logic [NL-1:0] m_led;
  logic [31:0]   m_boot;

  logic evt_seen, kp_seen, srst_seen;

  ecu_board_ctrl #(
    .NUM_KEYS(NK), .NUM_LEDS(NL), .DEBOUNCE_CYCLES(DEB), .RST_HOLD_CYCLES(HOLD),
    .BOOT_ADDR_0(B0), .BOOT_ADDR_1(B1)
  ) dut (
    .CLK_50(clk), .RESET_N(rst_n), .KEY(key), .gpio_i(gpio), .LEDR(ledr),
    .sys_reset_n(sys_reset_n), .jtag_reset(jtag_reset), .fetch_enable(fetch_enable),
    .boot_addr(boot_addr), .key_pressed(key_pressed), .key_event(key_event)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    dly0 = '1; dly1 = '1; m_kp = '0; m_evt = '0;
    for (int i = 0; i < NK; i++) streak[i] = 0;
    quiet = 0; m_bsel = 1'b0; m_srst = 1'b0; m_fe = 1'b0; m_jtag = 1'b0;
    m_led = '0; m_boot = B0;
  endtask

  task automatic model_edge();
    logic [NK-1:0] kp_old, synced;
    int            quiet_old;
    logic          bsel_old;
    if (!rst_n) return;
    kp_old    = m_kp;
    quiet_old = quiet;
    bsel_old  = m_bsel;
    synced    = ~dly1;
    dly1      = dly0;
    dly0      = key;
    for (int i = 0; i < NK; i++) begin
      if (synced[i] != kp_old[i]) begin
        streak[i]++;
        if (streak[i] == DEB) begin
          m_kp[i]   = ~kp_old[i];
          streak[i] = 0;
        end
      end else begin
        streak[i] = 0;
      end
    end
    m_evt  = m_kp & ~kp_old;
    m_jtag = kp_old[0];
    if (quiet_old == 0 && !kp_old[0]) m_bsel = kp_old[1];
    m_boot = m_bsel ? B1 : B0;
    m_srst = !kp_old[0] && (quiet_old > HOLD);
    m_fe   = !kp_old[0] && (quiet_old >= HOLD + 2);
    if (quiet_old > HOLD) begin
      m_led = gpio;
    end else begin
      m_led         = '0;
      m_led[NL-1]   = 1'b1;
      m_led[0]      = bsel_old;
    end
    quiet = kp_old[0] ? 0 : quiet_old + 1;
  endtask

  task automatic check_all();
    chk("ledr",         32'(ledr),         32'(m_led));
    chk("sys_reset_n",  32'(sys_reset_n),  32'(m_srst));
    chk("jtag_reset",   32'(jtag_reset),   32'(m_jtag));
    chk("fetch_enable", 32'(fetch_enable), 32'(m_fe));
    chk("boot_addr",    boot_addr,         m_boot);
    chk("key_pressed",  32'(key_pressed),  32'(m_kp));
    chk("key_event",    32'(key_event),    32'(m_evt));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    key   = '1;
    gpio  = '0;
    model_reset();

    // power-on reset values
    repeat (3) tick();

    // idle keys: release-to-run timing and default boot address
    gpio  = 10'h2A5;
    rst_n = 1'b1;
    repeat (9) tick();
    chk("srst_before_10", 32'(sys_reset_n), 32'd0);
    tick();
    chk("srst_at_10", 32'(sys_reset_n), 32'd1);
    chk("fe_at_10", 32'(fetch_enable), 32'd0);
    tick();
    chk("fe_at_11", 32'(fetch_enable), 32'd1);
    chk("boot_default", boot_addr, 32'h0000_8000);
    chk("ledr_gpio", 32'(ledr), 32'h2A5);

    // KEY[2] glitch shorter than the debounce window
    key[2] = 1'b0;
    repeat (3) tick();
    key[2]   = 1'b1;
    evt_seen = 1'b0;
    kp_seen  = 1'b0;
    repeat (8) begin
      tick();
      evt_seen |= key_event[2];
      kp_seen  |= key_pressed[2];
    end
    chk("glitch_kp2", 32'(kp_seen), 32'd0);
    chk("glitch_evt2", 32'(evt_seen), 32'd0);

    // KEY[2] clean press of 10 cycles
    key[2] = 1'b0;
    repeat (5) tick();
    chk("kp2_at5", 32'(key_pressed[2]), 32'd0);
    tick();
    chk("kp2_at6", 32'(key_pressed[2]), 32'd1);
    chk("evt2_at6", 32'(key_event[2]), 32'd1);
    tick();
    chk("evt2_at7", 32'(key_event[2]), 32'd0);
    repeat (3) tick();
    key[2] = 1'b1;
    repeat (8) tick();

    // KEY[0] reset press while running
    key[0] = 1'b0;
    repeat (20) tick();
    chk("press_jtag", 32'(jtag_reset), 32'd1);
    chk("press_srst", 32'(sys_reset_n), 32'd0);
    chk("press_fe", 32'(fetch_enable), 32'd0);
    chk("press_ledr", 32'(ledr), 32'h200);
    key[0] = 1'b1;
    repeat (15) tick();
    chk("rel_srst_15", 32'(sys_reset_n), 32'd0);
    tick();
    chk("rel_srst_16", 32'(sys_reset_n), 32'd1);

    // alternate boot address selected by KEY[1] across a reset
    key[1] = 1'b0;
    key[0] = 1'b0;
    repeat (20) tick();
    key[0] = 1'b1;
    repeat (10) tick();
    chk("alt_boot_hold", boot_addr, 32'h0000_0000);
    chk("alt_ledr_hold", 32'(ledr), 32'h201);
    repeat (10) tick();
    chk("alt_srst_run", 32'(sys_reset_n), 32'd1);
    key[1] = 1'b1;
    repeat (10) tick();
    chk("alt_boot_kept", boot_addr, 32'h0000_0000);
    chk("alt_ledr_run", 32'(ledr), 32'h2A5);

    // reset press arrives in HOLD with the hold count at 5
    key[0] = 1'b0;
    repeat (20) tick();
    key[0] = 1'b1;
    repeat (6) tick();
    key[0]    = 1'b0;
    srst_seen = 1'b0;
    repeat (20) begin
      tick();
      srst_seen |= sys_reset_n;
    end
    chk("hold_abort_srst", 32'(srst_seen), 32'd0);
    key[0] = 1'b1;
    repeat (25) tick();
    chk("hold_abort_recover", 32'(fetch_enable), 32'd1);

    // asynchronous RESET_N pulse mid-run
    pulse_reset();
    chk("async_boot", boot_addr, 32'h0000_8000);
    repeat (9) tick();
    chk("async_srst_9", 32'(sys_reset_n), 32'd0);
    tick();
    chk("async_srst_10", 32'(sys_reset_n), 32'd1);

    // randomized key activity and gpio traffic against the model
    for (int c = 0; c < 3000; c++) begin
      gpio = NL'($urandom);
      if ($urandom_range(3) == 0) key[2] = ~key[2];
      if ($urandom_range(3) == 0) key[3] = ~key[3];
      if ($urandom_range(15) == 0) key[1] = ~key[1];
      if ($urandom_range(47) == 0) key[0] = ~key[0];
      if (c == 1700) pulse_reset();
      else tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ecu_board_ctrl.md
ECU_BOARD_CTRL -- requirements
Module: ecu_board_ctrl

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 4: number of active-low push-buttons (min 2).
REQ-002 SHALL have parameter NUM_LEDS, default 10: LED/GPIO width.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500000: stable-cycle count for a key change (min 2).
REQ-004 SHALL have parameter RST_HOLD_CYCLES, default 1024: cycles system reset stays low after release (min 1).
REQ-005 SHALL have parameter BOOT_ADDR_0, default 32'h00008000: boot address when KEY[1] is released.
REQ-006 SHALL have parameter BOOT_ADDR_1, default 32'h00000000: boot address when KEY[1] is pressed.
REQ-007 SHALL have CLK_50  in  1  single system clock; all logic on its rising edge.
REQ-008 SHALL have RESET_N  in  1  asynchronous, active-low reset.
REQ-009 SHALL have KEY  in  NUM_KEYS  raw board buttons, 0 = pressed, asynchronous to CLK_50.
REQ-010 SHALL have gpio_i  in  NUM_LEDS  PIO output from the SoC.
REQ-011 SHALL have LEDR  out  NUM_LEDS  board LEDs.
REQ-012 SHALL have sys_reset_n  out  1  active-low reset to the SoC interconnect and core.
REQ-013 SHALL have jtag_reset  out  1  active-high reset to the JTAG master.
REQ-014 SHALL have fetch_enable  out  1  core fetch enable.
REQ-015 SHALL have boot_addr  out  32  core boot address.
REQ-016 SHALL have key_pressed  out  NUM_KEYS  debounced level per key, 1 = pressed.
REQ-017 SHALL have key_event  out  NUM_KEYS  one-cycle pulse per key on debounced press.

Function
REQ-018 Each KEY bit SHALL pass a 2-flop synchronizer, inverted so 1 = pressed.
REQ-019 Per key, a counter SHALL increment while the synchronized value differs from key_pressed and clear to 0 when equal.
REQ-020 key_pressed SHALL toggle, and the counter clear, on the cycle the counter reaches DEBOUNCE_CYCLES-1 with the value still differing: a clean edge is reflected DEBOUNCE_CYCLES+2 cycles after first sampled.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES cycles SHALL clear the counter and produce no change.
REQ-022 key_event[i] SHALL be 1 for exactly the cycle after key_pressed[i] goes 0->1; never on release.
REQ-023 Sequencer FSM states: RESET, HOLD, RUN.
REQ-024 RESET: sys_reset_n=0, fetch_enable=0; go HOLD when key_pressed[0]=0, clearing the hold counter and latching boot_addr = key_pressed[1] ? BOOT_ADDR_1 : BOOT_ADDR_0.
REQ-025 HOLD: sys_reset_n=0, counter increments; go RUN when counter = RST_HOLD_CYCLES-1; go RESET if key_pressed[0]=1 (press wins over counter expiry in the same cycle).
REQ-026 RUN: sys_reset_n=1; fetch_enable=1 from the second RUN cycle; go RESET on key_pressed[0]=1, dropping both sys_reset_n and fetch_enable on the next edge.
REQ-027 sys_reset_n and fetch_enable SHALL be registered outputs, glitch-free.
REQ-028 jtag_reset SHALL equal registered key_pressed[0].
REQ-029 boot_addr SHALL change only on RESET->HOLD; key_pressed[1] changes at other times are ignored.
REQ-030 LEDR SHALL be registered: gpio_i in RUN; in RESET/HOLD bit NUM_LEDS-1 = 1, bit 0 = boot select, others 0.
REQ-031 key_pressed[NUM_KEYS-1:2] SHALL only be debounced and reported, affecting no other output.

Reset
REQ-032 RESET_N low SHALL asynchronously force: FSM RESET, sys_reset_n=0, jtag_reset=0, fetch_enable=0, boot_addr=BOOT_ADDR_0, LEDR=0, key_pressed=0, key_event=0, synchronizer flops = released, counters=0.
REQ-033 RESET_N asserted mid-HOLD or mid-RUN SHALL abort immediately; after release the full sequence restarts from RESET.
REQ-034 After RESET_N release with keys idle, sys_reset_n SHALL rise RST_HOLD_CYCLES+2 cycles later (one in RESET, RST_HOLD_CYCLES in HOLD, one to register).

Verification (DEBOUNCE_CYCLES=4, RST_HOLD_CYCLES=8, NUM_KEYS=4, NUM_LEDS=10)
REQ-035 Release RESET_N, keys idle -> sys_reset_n rises 10 cycles later, fetch_enable one cycle after that, boot_addr=32'h00008000, LEDR follows gpio_i=10'h2A5.
REQ-036 KEY[2] low for 3 cycles then high -> key_pressed[2] stays 0, no key_event; low for 10 cycles -> key_pressed[2]=1 6 cycles after the edge, key_event[2] one-cycle pulse.
REQ-037 In RUN, KEY[0] held low 20 cycles -> jtag_reset=1, sys_reset_n=0, fetch_enable=0, LEDR=10'h200; after release, sys_reset_n returns after debounce + 10 cycles.
REQ-038 KEY[1] held pressed during reset sequence -> boot_addr=32'h00000000, LEDR=10'h201 in HOLD; releasing KEY[1] in RUN leaves boot_addr unchanged.
REQ-039 KEY[0] pressed during HOLD at counter 5 -> FSM returns to RESET, sys_reset_n never pulses high.
REQ-040 RESET_N pulsed low mid-RUN for 1 cycle -> all outputs take REQ-032 values asynchronously, full sequence repeats.
